// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and helpers for the iterative RV32M multiply/divide unit.
//   muldiv_op_t    - funct3 encoding of the eight M-extension ops
//   muldiv_state_t - FSM states of muldiv_unit
//   XLEN           - architectural operand width
//   is_signed_a/b  - whether rs1/rs2 are treated as two's complement for an op
//   is_div         - op belongs to the divide/remainder group
package muldiv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } muldiv_state_t;

    function automatic logic is_signed_a(input muldiv_op_t op);
        return !(op == OP_MULHU || op == OP_DIVU || op == OP_REMU);
    endfunction

    function automatic logic is_signed_b(input muldiv_op_t op);
        return (op == OP_MULH || op == OP_DIV || op == OP_REM);
    endfunction

    // funct3[2] splits the multiply group from the divide group
    function automatic logic is_div(input muldiv_op_t op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the unsigned magnitude datapath.
//   is_div   in  1      0: shift-add multiply step, 1: restoring divide step
//   acc      in  2*W    mul: {partial hi, remaining multiplier}; div: {rem, quo}
//   divisor  in  W      multiplicand magnitude (mul) or divisor magnitude (div)
//   acc_next out 2*W    accumulator after this iteration
module muldiv_step #(
    parameter int W = 32
) (
    input  logic           is_div,
    input  logic [2*W-1:0] acc,
    input  logic [W-1:0]   divisor,
    output logic [2*W-1:0] acc_next
);

    logic [W:0]   mul_sum;
    logic         fits;
    logic [W-1:0] diff;

    always_comb begin
        // Multiply: add multiplicand into the high half when the current
        // multiplier bit is set, then shift the whole 65-bit value right.
        mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, divisor} : '0);

        // Divide: partial remainder shifted left is {acc[2W-1], acc[2W-2:W-1]}.
        // If its top bit is set it already exceeds any W-bit divisor, and the
        // W-bit wrapped difference is then exact since the true result < divisor.
        fits = acc[2*W-1] || (acc[2*W-2:W-1] >= divisor);
        diff = acc[2*W-2:W-1] - divisor;

        if (!is_div)
            acc_next = {mul_sum, acc[W-1:1]};
        else if (fits)
            acc_next = {diff, acc[W-2:0], 1'b1};
        else
            acc_next = {acc[2*W-2:0], 1'b0};
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the EX stage.
// Fixed 35-cycle latency from accepted start to done for every op.
//   clk     in   1     rising-edge clock
//   reset   in   1     synchronous, active-high
//   start   in   1     request, honoured only in IDLE or DONE
//   op      in   3     muldiv_op_t (funct3 encoding)
//   a, b    in   XLEN  rs1 / rs2, captured on accepted start
//   flush   in   1     abandon in-flight op, return to IDLE
//   busy    out  1     high in PREP, CALC, FIX
//   done    out  1     one-cycle pulse in DONE
//   result  out  XLEN  registered, updated only on the edge entering DONE
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  muldiv_op_t       op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [XLEN-1:0]  result
);

    localparam int CNT_W = $clog2(XLEN);

    muldiv_state_t     state;
    muldiv_op_t        op_r;
    logic [XLEN-1:0]   a_r, b_r;
    logic [XLEN-1:0]   divisor;
    logic [2*XLEN-1:0] acc;
    logic [CNT_W-1:0]  cnt;
    logic              sa, sb;

    // PREP-cycle sign extraction and magnitude conversion
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   mag_a, mag_b;

    // FIX-cycle result selection
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;
    logic              div0, ovf;
    logic [XLEN-1:0]   fix_result;

    logic [2*XLEN-1:0] step_acc;

    muldiv_step #(.W(XLEN)) u_step (
        .is_div   (is_div(op_r)),
        .acc      (acc),
        .divisor  (divisor),
        .acc_next (step_acc)
    );

    always_comb begin
        a_neg = is_signed_a(op_r) & a_r[XLEN-1];
        b_neg = is_signed_b(op_r) & b_r[XLEN-1];
        mag_a = a_neg ? -a_r : a_r;
        mag_b = b_neg ? -b_r : b_r;
    end

    always_comb begin
        prod = (sa ^ sb) ? -acc : acc;
        quo  = (sa ^ sb) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = sa ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        div0 = (b_r == '0);
        ovf  = (op_r == OP_DIV || op_r == OP_REM) &&
               (a_r == {1'b1, {(XLEN-1){1'b0}}}) && (b_r == '1);
        case (op_r)
            OP_MUL:                       fix_result = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:
                if (div0)     fix_result = '1;
                else if (ovf) fix_result = {1'b1, {(XLEN-1){1'b0}}};
                else          fix_result = quo;
            default:
                if (div0)     fix_result = a_r;
                else if (ovf) fix_result = '0;
                else          fix_result = rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            cnt     <= '0;
            op_r    <= OP_MUL;
            a_r     <= '0;
            b_r     <= '0;
            divisor <= '0;
            acc     <= '0;
            sa      <= 1'b0;
            sb      <= 1'b0;
        end else if (flush) begin
            // flush beats a coincident start; result is left untouched
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= ST_PREP;
                        busy  <= 1'b1;
                        op_r  <= op;
                        a_r   <= a;
                        b_r   <= b;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_PREP: begin
                    sa      <= a_neg;
                    sb      <= b_neg;
                    divisor <= mag_b;
                    // same initial layout for both groups: low half holds
                    // the multiplier / dividend magnitude
                    acc     <= {{XLEN{1'b0}}, mag_a};
                    cnt     <= CNT_W'(XLEN - 1);
                    state   <= ST_CALC;
                end
                ST_CALC: begin
                    acc <= step_acc;
                    if (cnt == '0) state <= ST_FIX;
                    else           cnt   <= cnt - 1'b1;
                end
                ST_FIX: begin
                    result <= fix_result;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    muldiv_op_t  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;
    int busy_n, overlap;

    muldiv_unit dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic step_cyc();
        @(posedge clk);
        #1;
    endtask

    // Advance until done (n = edges advanced) or budget expires (n = -1).
    task automatic wait_done(input int budget, output int n);
        n = -1;
        busy_n = 0;
        overlap = 0;
        for (int i = 0; i < budget; i++) begin
            if (busy) busy_n++;
            if (busy && done) overlap++;
            if (done) begin
                n = i;
                break;
            end
            step_cyc();
        end
    endtask

    // Issue one op; lat is the cycle offset of done relative to the accept edge.
    task automatic do_op(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] res, output int lat);
        int n;
        op = o; a = x; b = y; start = 1'b1;
        step_cyc();
        start = 1'b0;
        a = $urandom; b = $urandom;   // operands must have been captured already
        wait_done(60, n);
        lat = (n < 0) ? -1 : n + 1;
        res = result;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; flush = 1'b0; op = OP_MUL; a = '0; b = '0;
        repeat (3) step_cyc();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result); end
        reset = 1'b0;
        step_cyc();
    endtask

    task automatic test_mul();
        logic [31:0] r; int lat;
        do_op(OP_MUL, 32'd7, 32'hFFFF_FFFD, r, lat);
        n_checks++; if (r !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mul_7x-3: got %h want ffffffeb", r); end
        n_checks++; if (lat !== 35) begin n_fail++; $display("FAIL mul_latency: got %0d want 35", lat); end
        n_checks++; if (busy_n !== 34) begin n_fail++; $display("FAIL mul_busy_cycles: got %0d want 34", busy_n); end
        n_checks++; if (overlap !== 0) begin n_fail++; $display("FAIL busy_done_overlap: got %0d want 0", overlap); end
        step_cyc();
        do_op(OP_MULH, 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
        n_checks++; if (r !== 32'h0000_0000) begin n_fail++; $display("FAIL mulh: got %h want 00000000", r); end
        step_cyc();
        do_op(OP_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
        n_checks++; if (r !== 32'h8000_0000) begin n_fail++; $display("FAIL mulhsu: got %h want 80000000", r); end
        step_cyc();
        do_op(OP_MULHU, 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
        n_checks++; if (r !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL mulhu: got %h want 7fffffff", r); end
        step_cyc();
    endtask

    task automatic test_div();
        logic [31:0] r; int lat;
        do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, r, lat);
        n_checks++; if (r !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_-7/2: got %h want fffffffd", r); end
        n_checks++; if (lat !== 35) begin n_fail++; $display("FAIL div_latency: got %0d want 35", lat); end
        step_cyc();
        do_op(OP_REM, 32'hFFFF_FFF9, 32'd2, r, lat);
        n_checks++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rem_-7/2: got %h want ffffffff", r); end
        step_cyc();
        do_op(OP_DIVU, 32'd100, 32'd7, r, lat);
        n_checks++; if (r !== 32'd14) begin n_fail++; $display("FAIL divu_100/7: got %h want 0000000e", r); end
        step_cyc();
        do_op(OP_REMU, 32'd100, 32'd7, r, lat);
        n_checks++; if (r !== 32'd2) begin n_fail++; $display("FAIL remu_100/7: got %h want 00000002", r); end
        step_cyc();
    endtask

    task automatic test_special();
        logic [31:0] r; int lat;
        do_op(OP_DIV, 32'd5, 32'd0, r, lat);
        n_checks++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_by_zero: got %h want ffffffff", r); end
        n_checks++; if (lat !== 35) begin n_fail++; $display("FAIL div0_latency: got %0d want 35", lat); end
        step_cyc();
        do_op(OP_REM, 32'd5, 32'd0, r, lat);
        n_checks++; if (r !== 32'd5) begin n_fail++; $display("FAIL rem_by_zero: got %h want 00000005", r); end
        step_cyc();
        do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
        n_checks++; if (r !== 32'h8000_0000) begin n_fail++; $display("FAIL div_overflow: got %h want 80000000", r); end
        step_cyc();
        do_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
        n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL rem_overflow: got %h want 00000000", r); end
        step_cyc();
    endtask

    // A start pulse while busy must not restart or replace the running op.
    task automatic test_ignore_start();
        int n, lat;
        op = OP_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
        step_cyc();                    // cycle k+1
        start = 1'b0;
        repeat (4) step_cyc();         // cycle k+5
        op = OP_REMU; a = 32'd9; b = 32'd4; start = 1'b1;
        step_cyc();                    // cycle k+6
        start = 1'b0;
        wait_done(60, n);
        lat = (n < 0) ? -1 : n + 6;
        n_checks++; if (lat !== 35) begin n_fail++; $display("FAIL ignore_start_latency: got %0d want 35", lat); end
        n_checks++; if (result !== 32'd14) begin n_fail++; $display("FAIL ignore_start_result: got %h want 0000000e", result); end
        step_cyc();
    endtask

    task automatic test_flush();
        int n;
        op = OP_DIV; a = 32'hFFFF_FF9C; b = 32'd7; start = 1'b1;
        step_cyc();                    // cycle k+1
        start = 1'b0;
        repeat (9) step_cyc();         // cycle k+10
        flush = 1'b1;
        step_cyc();                    // cycle k+11
        flush = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL flush_done: got %b want 0", done); end
        n_checks++; if (result !== 32'd14) begin n_fail++; $display("FAIL flush_result: got %h want 0000000e", result); end
        wait_done(45, n);
        n_checks++; if (n !== -1) begin n_fail++; $display("FAIL flush_no_done: got done after %0d cycles want none", n); end
        n_checks++; if (result !== 32'd14) begin n_fail++; $display("FAIL flush_result_kept: got %h want 0000000e", result); end
        // flush and start together: start is dropped
        op = OP_MUL; a = 32'd3; b = 32'd3; start = 1'b1; flush = 1'b1;
        step_cyc();
        start = 1'b0; flush = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_start_busy: got %b want 0", busy); end
        wait_done(40, n);
        n_checks++; if (n !== -1) begin n_fail++; $display("FAIL flush_start_no_done: got done after %0d cycles want none", n); end
    endtask

    task automatic test_back_to_back();
        int n1, n2;
        op = OP_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
        step_cyc();                    // cycle k+1
        op = OP_REMU;                  // second request, presented while start stays high
        wait_done(60, n1);             // cycle k+35 when done
        n_checks++; if (n1 + 1 !== 35) begin n_fail++; $display("FAIL b2b_first_latency: got %0d want 35", n1 + 1); end
        n_checks++; if (result !== 32'd14) begin n_fail++; $display("FAIL b2b_first_result: got %h want 0000000e", result); end
        step_cyc();                    // cycle k+36, second op already in PREP
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_no_bubble: busy got %b want 1", busy); end
        wait_done(60, n2);
        n_checks++; if (n2 + 1 !== 35) begin n_fail++; $display("FAIL b2b_done_spacing: got %0d want 35", n2 + 1); end
        n_checks++; if (result !== 32'd2) begin n_fail++; $display("FAIL b2b_second_result: got %h want 00000002", result); end
        step_cyc();
    endtask

    task automatic test_reset_mid_op();
        int n;
        op = OP_MUL; a = 32'd7; b = 32'hFFFF_FFFD; start = 1'b1;
        step_cyc();                    // cycle k+1
        start = 1'b0;
        repeat (19) step_cyc();        // cycle k+20
        reset = 1'b1;
        step_cyc();                    // cycle k+21
        reset = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midreset_done: got %b want 0", done); end
        n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL midreset_result: got %h want 0", result); end
        wait_done(45, n);
        n_checks++; if (n !== -1) begin n_fail++; $display("FAIL midreset_no_done: got done after %0d cycles want none", n); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_ignore_start();
        test_flush();
        test_back_to_back();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
